// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall-vector semantics (advance / hold / bubble),
// exception flush, and saturating hold / bubble performance counters.
module pipe_stage_reg #(
   parameter int unsigned          DATA_W  = 64,
   parameter logic [DATA_W-1:0]    NOP_VAL = {DATA_W{1'b0}},
   parameter int unsigned          STALL_W = 6,
   parameter int unsigned          STAGE   = 2,
   parameter int unsigned          CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_fb,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               fb_o,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   hold_cnt,
   output logic [CNT_W-1:0]   bubble_cnt
);

   // The downstream stall bit must exist in the stall vector.
   if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE+1 must be less than STALL_W");
   end

   typedef enum logic [1:0] {
      ActAdvance,
      ActHold,
      ActBubble,
      ActFlush
   } action_e;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   action_e             action;
   logic                s_up;
   logic                s_dn;

   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                fb_q, fb_d;
   logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

   assign s_up = stall[STAGE];
   assign s_dn = stall[STAGE+1];

   // Decode this cycle's action; flush outranks every stall combination.
   always_comb begin
      action = ActAdvance;
      if (flush) begin
         action = ActFlush;
      end else if (s_up && s_dn) begin
         action = ActHold;
      end else if (s_up) begin
         action = ActBubble;
      end
   end

   // Next payload / valid / feedback state for the decoded action.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      fb_d    = fb_q;
      unique case (action)
         ActAdvance: begin
            valid_d = in_valid;
            data_d  = in_data;
            fb_d    = in_fb;
         end
         ActHold: begin
            valid_d = valid_q;
            data_d  = data_q;
            fb_d    = fb_q;
         end
         ActBubble, ActFlush: begin
            valid_d = 1'b0;
            data_d  = NOP_VAL;
            fb_d    = 1'b0;
         end
         default: begin
            valid_d = valid_q;
            data_d  = data_q;
            fb_d    = fb_q;
         end
      endcase
   end

   // Saturating counters; holding a bubble is not a lost cycle, so it is not counted.
   always_comb begin
      hold_cnt_d   = hold_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (action == ActHold && valid_q && hold_cnt_q != CntMax) begin
         hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
      if (action == ActBubble && bubble_cnt_q != CntMax) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
      if (cnt_clr) begin
         hold_cnt_d   = '0;
         bubble_cnt_d = '0;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         data_q       <= NOP_VAL;
         fb_q         <= 1'b0;
         hold_cnt_q   <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         fb_q         <= fb_d;
         hold_cnt_q   <= hold_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign fb_o       = fb_q;
   assign hold_cnt   = hold_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of the stage register.
module tb_pipe_stage_reg;

   localparam int unsigned       DATA_W  = 32;
   localparam logic [31:0]       NOP_VAL = 32'h0000_0013;
   localparam int unsigned       STALL_W = 6;
   localparam int unsigned       STAGE   = 2;
   localparam int unsigned       CNT_W   = 4;
   localparam int                CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic               in_valid;
   logic [DATA_W-1:0]  in_data;
   logic               in_fb;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic               fb_o;
   logic               cnt_clr;
   logic [CNT_W-1:0]   hold_cnt;
   logic [CNT_W-1:0]   bubble_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state.
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_fb;
   int                m_hold;
   int                m_bub;

   pipe_stage_reg #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL),
      .STALL_W (STALL_W),
      .STAGE   (STAGE),
      .CNT_W   (CNT_W)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_fb      (in_fb),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .fb_o       (fb_o),
      .cnt_clr    (cnt_clr),
      .hold_cnt   (hold_cnt),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock edge of the behavioural model, from the rules for each action.
   task automatic model_step();
      bit up, dn;
      up = stall[STAGE];
      dn = stall[STAGE+1];
      if (rst) begin
         m_valid = 1'b0; m_data = NOP_VAL; m_fb = 1'b0; m_hold = 0; m_bub = 0;
         return;
      end
      if (flush) begin
         m_valid = 1'b0; m_data = NOP_VAL; m_fb = 1'b0;
      end else if (!up) begin
         m_valid = in_valid; m_data = in_data; m_fb = in_fb;
      end else if (dn) begin
         if (m_valid) m_hold = (m_hold + 1 > CNT_MAX) ? CNT_MAX : m_hold + 1;
      end else begin
         m_valid = 1'b0; m_data = NOP_VAL; m_fb = 1'b0;
         m_bub = (m_bub + 1 > CNT_MAX) ? CNT_MAX : m_bub + 1;
      end
      if (cnt_clr) begin
         m_hold = 0; m_bub = 0;
      end
   endtask

   // Advance one edge, update the model, then compare every output just after the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("out_valid",  64'(out_valid),  64'(m_valid));
      check("out_data",   64'(out_data),   64'(m_data));
      check("fb_o",       64'(fb_o),       64'(m_fb));
      check("hold_cnt",   64'(hold_cnt),   64'(m_hold));
      check("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
   endtask

   task automatic drive(input logic r, input logic [STALL_W-1:0] s, input logic f,
                        input logic v, input logic [DATA_W-1:0] d, input logic fb,
                        input logic clr);
      rst = r; stall = s; flush = f; in_valid = v; in_data = d; in_fb = fb; cnt_clr = clr;
   endtask

   initial begin
      m_valid = 1'b0; m_data = NOP_VAL; m_fb = 1'b0; m_hold = 0; m_bub = 0;
      drive(1'b1, 6'b000000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      tick();
      check("rst_data",  64'(out_data),  64'(NOP_VAL));
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_cnt",   64'({hold_cnt, bubble_cnt}), 64'd0);

      // Advance.
      drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b0);
      tick();
      check("adv_data", 64'(out_data), 64'h1234);
      check("adv_fb",   64'(fb_o),     64'd1);

      // Hold three edges while upstream data churns.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 6'b001100, 1'b0, 1'b1, $urandom, 1'(i), 1'b0);
         tick();
      end
      check("hold_data", 64'(out_data), 64'h1234);
      check("hold_fb",   64'(fb_o),     64'd1);
      check("hold_cnt3", 64'(hold_cnt), 64'd3);
      drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
      tick();
      check("after_hold", 64'(out_data), 64'h55);

      // Two bubbles, then a hold of the bubble is not counted.
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 6'b000100, 1'b0, 1'b1, $urandom, 1'b1, 1'b0);
         tick();
      end
      check("bub_data",  64'(out_data),   64'(NOP_VAL));
      check("bub_valid", 64'(out_valid),  64'd0);
      check("bub_cnt2",  64'(bubble_cnt), 64'd2);
      drive(1'b0, 6'b001100, 1'b0, 1'b1, $urandom, 1'b1, 1'b0);
      tick();
      check("hold_bub", 64'(hold_cnt), 64'd3);

      // Flush beats HOLD and ADVANCE, without touching counters.
      drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'h77, 1'b1, 1'b0);
      tick();
      drive(1'b0, 6'b001100, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0);
      tick();
      check("flh_valid", 64'(out_valid), 64'd0);
      check("flh_data",  64'(out_data),  64'(NOP_VAL));
      check("flh_cnt",   64'({hold_cnt, bubble_cnt}), 64'({4'd3, 4'd2}));
      drive(1'b0, 6'b000000, 1'b1, 1'b1, 32'h88, 1'b1, 1'b0);
      tick();
      check("fla_data", 64'(out_data), 64'(NOP_VAL));

      // Saturation, then clear during a hold.
      drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'hAA, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 6'b001100, 1'b0, 1'b0, $urandom, 1'b0, 1'b0);
         tick();
      end
      check("hold_sat", 64'(hold_cnt), 64'd15);
      drive(1'b0, 6'b001100, 1'b0, 1'b0, $urandom, 1'b0, 1'b1);
      tick();
      check("clr_hold", 64'(hold_cnt), 64'd0);
      drive(1'b0, 6'b001100, 1'b0, 1'b0, $urandom, 1'b0, 1'b0);
      tick();
      check("clr_next", 64'(hold_cnt), 64'd1);

      // Random traffic, including ignored stall bits.
      for (int i = 0; i < 2000; i++) begin
         drive(1'(($urandom % 64) == 0), STALL_W'($urandom), 1'(($urandom % 8) == 0),
               1'($urandom), $urandom, 1'($urandom), 1'(($urandom % 40) == 0));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
